// File: rtl/snd_gain_mixer4_pkg.sv
// Shared constants for the four-channel gain mixer.
// Gains are unsigned 4.4 fixed point; the sum carries extra headroom bits so nothing wraps.
package snd_gain_mixer4_pkg;

    localparam logic [7:0]  GainUnity    = 8'h10;
    localparam int unsigned GainFracBits = 4;
    localparam int unsigned SumHeadroom  = 10;

endpackage

// File: rtl/snd_mix_scale.sv
// One mixer channel: MSB-align a signed sample to wout bits and multiply by a 4.4 gain.
// Purely combinational; the product is exact in wout+8 signed bits.
module snd_mix_scale #(
    parameter int unsigned win  = 16,
    parameter int unsigned wout = 16
) (
    input  logic signed [win-1:0]    ch,
    input  logic        [7:0]        gain,
    output logic signed [wout+7:0]   prod
);

    logic signed [wout-1:0] ch_ext;
    logic signed [wout-1:0] aligned;
    logic signed [8:0]      gain_s;

    always_comb begin
        ch_ext  = wout'(ch);
        // Left shift keeps the sign bit at the MSB, so full scale maps to full scale
        aligned = ch_ext <<< (wout - win);
        gain_s  = $signed({1'b0, gain});
        prod    = (wout+8)'(aligned) * (wout+8)'(gain_s);
    end

endmodule

// File: rtl/snd_gain_mixer4.sv
// Four-input signed audio mixer with per-channel 4.4 gain, 1/16 rescale and output clip.
// Two cen-qualified pipeline stages: products, then sum/shift/saturate.
module snd_gain_mixer4
    import snd_gain_mixer4_pkg::*;
#(
    parameter int unsigned w0   = 16,
    parameter int unsigned w1   = 16,
    parameter int unsigned w2   = 16,
    parameter int unsigned w3   = 16,
    parameter int unsigned wout = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cen,
    input  logic signed [w0-1:0]   ch0,
    input  logic signed [w1-1:0]   ch1,
    input  logic signed [w2-1:0]   ch2,
    input  logic signed [w3-1:0]   ch3,
    input  logic        [7:0]      gain0,
    input  logic        [7:0]      gain1,
    input  logic        [7:0]      gain2,
    input  logic        [7:0]      gain3,
    output logic signed [wout-1:0] mixed
);

    localparam int unsigned PW   = wout + 8;
    localparam int unsigned SumW = wout + SumHeadroom;

    logic signed [PW-1:0]   p0, p1, p2, p3;
    logic signed [PW-1:0]   p0_q, p1_q, p2_q, p3_q;
    logic signed [SumW-1:0] sum;
    logic signed [SumW-1:0] shifted;
    logic signed [wout-1:0] mixed_d;

    snd_mix_scale #(.win(w0), .wout(wout)) u_scale0 (.ch(ch0), .gain(gain0), .prod(p0));
    snd_mix_scale #(.win(w1), .wout(wout)) u_scale1 (.ch(ch1), .gain(gain1), .prod(p1));
    snd_mix_scale #(.win(w2), .wout(wout)) u_scale2 (.ch(ch2), .gain(gain2), .prod(p2));
    snd_mix_scale #(.win(w3), .wout(wout)) u_scale3 (.ch(ch3), .gain(gain3), .prod(p3));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else if (cen) begin
            p0_q <= p0;
            p1_q <= p1;
            p2_q <= p2;
            p3_q <= p3;
        end
    end

    always_comb begin
        sum     = SumW'(p0_q) + SumW'(p1_q) + SumW'(p2_q) + SumW'(p3_q);
        // Arithmetic shift floors toward minus infinity
        shifted = sum >>> GainFracBits;
        // In range only when every bit above the output sign bit matches it
        if (shifted[SumW-1:wout-1] == '0 || shifted[SumW-1:wout-1] == '1) begin
            mixed_d = shifted[wout-1:0];
        end else if (shifted[SumW-1]) begin
            mixed_d = {1'b1, {(wout-1){1'b0}}};
        end else begin
            mixed_d = {1'b0, {(wout-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mixed <= '0;
        end else if (cen) begin
            mixed <= mixed_d;
        end
    end

endmodule

// File: tb/tb_snd_gain_mixer4.sv
// Directed-vector bench for snd_gain_mixer4 (ch2 narrowed to 10 bits, wout=16).
module tb_snd_gain_mixer4;
    import snd_gain_mixer4_pkg::*;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cen = 1'b0;
    logic signed [15:0] ch0 = '0, ch1 = '0, ch3 = '0;
    logic signed [9:0]  ch2 = '0;
    logic [7:0]         gain0 = '0, gain1 = '0, gain2 = '0, gain3 = '0;
    logic signed [15:0] mixed;

    int n_cmp = 0;
    int n_bad = 0;

    snd_gain_mixer4 #(.w0(16), .w1(16), .w2(10), .w3(16), .wout(16)) dut (
        .clk(clk), .rstn(rstn), .cen(cen),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
        .mixed(mixed)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 16'h%04h expected 16'h%04h", tag, got, exp);
        end
    endtask

    // One cen-qualified edge; returns just after the following negedge
    task automatic cen_pulse();
        @(negedge clk) cen = 1'b1;
        @(negedge clk) cen = 1'b0;
        #1;
    endtask

    task automatic set_in(input logic [15:0] c0, input logic [15:0] c1, input logic [9:0] c2,
                          input logic [15:0] c3, input logic [7:0] g0, input logic [7:0] g1,
                          input logic [7:0] g2, input logic [7:0] g3);
        @(negedge clk);
        ch0 = c0; ch1 = c1; ch2 = c2; ch3 = c3;
        gain0 = g0; gain1 = g1; gain2 = g2; gain3 = g3;
    endtask

    task automatic mix_case(input string tag, input logic [15:0] c0, input logic [15:0] c1,
                            input logic [9:0] c2, input logic [15:0] c3, input logic [7:0] g0,
                            input logic [7:0] g1, input logic [7:0] g2, input logic [7:0] g3,
                            input logic [15:0] exp);
        set_in(c0, c1, c2, c3, g0, g1, g2, g3);
        cen_pulse();
        cen_pulse();
        check_val(tag, mixed, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset", mixed, 16'h0000);
        set_in(16'h1000, 0, 0, 0, GainUnity, 0, 0, 0);
        rstn = 1'b1;
        cen_pulse();
        check_val("unity_lat1", mixed, 16'h0000);
        cen_pulse();
        check_val("unity_lat2", mixed, 16'h1000);

        mix_case("narrow_pos",  0, 0, 10'h100, 0, 0, 0, GainUnity, 0, 16'h4000);
        mix_case("narrow_neg1", 0, 0, 10'h3FF, 0, 0, 0, GainUnity, 0, 16'hFFC0);
        mix_case("sat_pos", 16'h7000, 16'h7000, 0, 0, GainUnity, GainUnity, 0, 0, 16'h7FFF);
        mix_case("sat_neg", 16'h8000, 16'h8000, 0, 0, GainUnity, GainUnity, 0, 0, 16'h8000);
        mix_case("gain_half",  16'h2000, 0, 0, 0, 8'h08, 0, 0, 0, 16'h1000);
        mix_case("gain_x2",    16'h2000, 0, 0, 0, 8'h20, 0, 0, 0, 16'h4000);
        mix_case("gain_max",   16'h0100, 0, 0, 0, 8'hFF, 0, 0, 0, 16'h0FF0);
        mix_case("gain_zero",  16'h7FFF, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0000);
        // -1 * 1/16 floors to -1, not 0
        mix_case("floor_neg",  16'hFFFF, 0, 0, 0, 8'h01, 0, 0, 0, 16'hFFFF);
        mix_case("single_ovf", 16'h8000, 0, 0, 0, 8'hFF, 0, 0, 0, 16'h8000);
        mix_case("sum4_ovf", 16'h7FFF, 16'h7FFF, 10'h1FF, 16'h7FFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                 16'h7FFF);
        // 0x1000 + 0x0800 + (0x40<<6 = 0x1000)*0.5 - 0x0400 = 0x1C00
        mix_case("mix_all", 16'h1000, 16'h0800, 10'h040, 16'hFC00, GainUnity, GainUnity,
                 8'h08, GainUnity, 16'h1C00);

        mix_case("pre_gate", 16'h1000, 0, 0, 0, GainUnity, 0, 0, 0, 16'h1000);
        set_in(16'h2000, 0, 0, 0, GainUnity, 0, 0, 0);
        repeat (10) @(negedge clk);
        #1;
        check_val("cen_hold", mixed, 16'h1000);
        cen_pulse();
        check_val("cen_lat1", mixed, 16'h1000);
        cen_pulse();
        check_val("cen_lat2", mixed, 16'h2000);

        mix_case("pre_reset", 16'h1000, 0, 0, 0, GainUnity, 0, 0, 0, 16'h1000);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_val("async_rst", mixed, 16'h0000);
        @(negedge clk) rstn = 1'b1;
        cen_pulse();
        check_val("rst_lat1", mixed, 16'h0000);
        cen_pulse();
        check_val("rst_lat2", mixed, 16'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
